// File: rtl/programmable_timer_if.sv
// CPU I/O-page bus used by the timers block.
//   bus_addr      12-bit data address
//   bus_write_en  1-clk write strobe
//   bus_read_en   1-clk read strobe
//   bus_data_in   4-bit write data
//   bus_data_out  4-bit read data, driven by the addressed peripheral
// master: CPU side, slave: peripheral side.
interface programmable_timer_if;
    logic [11:0] bus_addr;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [3:0]  bus_data_in;
    logic [3:0]  bus_data_out;

    modport master (
        output bus_addr,
        output bus_write_en,
        output bus_read_en,
        output bus_data_in,
        input  bus_data_out
    );

    modport slave (
        input  bus_addr,
        input  bus_write_en,
        input  bus_read_en,
        input  bus_data_in,
        output bus_data_out
    );
endinterface

// File: rtl/programmable_timer.sv
// 8-bit reloadable down-counter clocked by a selectable prescaler tick.
// On underflow (counter at 1 when a tick arrives) the counter reloads and
// the PT interrupt factor is raised; interrupt_req is factor & mask, registered.
// Ports:
//   clk            system clock (32.768 kHz timebase)
//   reset_n        asynchronous active-low reset
//   bus            slave side of the I/O-page bus
//   interrupt_req  registered factor & mask
module programmable_timer #(
    parameter int         DIV_WIDTH    = 7,
    parameter logic [7:0] RELOAD_RESET = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    programmable_timer_if.slave  bus,
    output logic                 interrupt_req
);

    localparam logic [11:0] ADDR_CNT_LO = 12'hF24;
    localparam logic [11:0] ADDR_SHADOW = 12'hF25;
    localparam logic [11:0] ADDR_RLD_LO = 12'hF78;
    localparam logic [11:0] ADDR_RLD_HI = 12'hF79;
    localparam logic [11:0] ADDR_CTRL   = 12'hF7D;
    localparam logic [11:0] ADDR_PTC    = 12'hF7E;
    localparam logic [11:0] ADDR_FACTOR = 12'hF03;
    localparam logic [11:0] ADDR_MASK   = 12'hF13;

    localparam logic [DIV_WIDTH-1:0] DIV_ONES = '1;

    logic [DIV_WIDTH-1:0] divider;
    logic [7:0]           counter;
    logic [7:0]           reload;
    logic [3:0]           shadow;
    logic [2:0]           ptc;
    logic                 run;
    logic                 factor;
    logic                 mask;

    logic                 wr_rld_lo, wr_rld_hi, wr_ctrl, wr_ptc, wr_mask;
    logic                 rd_cnt_lo, rd_factor;
    logic                 ptrst;
    logic                 run_eff;
    logic                 tick;
    logic                 tick_en;
    logic [DIV_WIDTH-1:0] sel_mask;
    logic                 count_en;
    logic                 underflow;
    logic [3:0]           rd_data;

    assign wr_rld_lo = bus.bus_write_en && (bus.bus_addr == ADDR_RLD_LO);
    assign wr_rld_hi = bus.bus_write_en && (bus.bus_addr == ADDR_RLD_HI);
    assign wr_ctrl   = bus.bus_write_en && (bus.bus_addr == ADDR_CTRL);
    assign wr_ptc    = bus.bus_write_en && (bus.bus_addr == ADDR_PTC);
    assign wr_mask   = bus.bus_write_en && (bus.bus_addr == ADDR_MASK);
    assign rd_cnt_lo = bus.bus_read_en  && (bus.bus_addr == ADDR_CNT_LO);
    assign rd_factor = bus.bus_read_en  && (bus.bus_addr == ADDR_FACTOR);

    assign ptrst = wr_ctrl && bus.bus_data_in[1];

    // A tick on the same edge as a run write only counts if the timer was
    // already running and is not being stopped by that write.
    assign run_eff = run && !(wr_ctrl && !bus.bus_data_in[0]);

    // The selected divider bit rolls over on the edge after all bits at and
    // below it are ones, so the tick is asserted during that last cycle.
    always_comb begin
        sel_mask = '0;
        tick_en  = 1'b0;
        case (ptc)
            3'd4: begin sel_mask = DIV_ONES;      tick_en = 1'b1; end
            3'd5: begin sel_mask = DIV_ONES >> 1; tick_en = 1'b1; end
            3'd6: begin sel_mask = DIV_ONES >> 2; tick_en = 1'b1; end
            3'd7: begin sel_mask = DIV_ONES >> 3; tick_en = 1'b1; end
            default: begin sel_mask = '0;         tick_en = 1'b0; end
        endcase
    end

    assign tick      = tick_en && ((divider & sel_mask) == sel_mask);
    assign count_en  = tick && run_eff && !ptrst;
    assign underflow = count_en && (counter == 8'h01);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= 8'h00;
        end else if (ptrst) begin
            counter <= reload;
        end else if (count_en) begin
            if (counter == 8'h01) begin
                counter <= reload;
            end else begin
                counter <= counter - 8'h01;
            end
        end
    end

    // Set on underflow wins over the clear-on-read of the factor register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            factor <= 1'b0;
        end else if (underflow) begin
            factor <= 1'b1;
        end else if (rd_factor) begin
            factor <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload        <= RELOAD_RESET;
            shadow        <= 4'h0;
            ptc           <= 3'b000;
            run           <= 1'b0;
            mask          <= 1'b0;
            interrupt_req <= 1'b0;
        end else begin
            if (wr_rld_lo) reload[3:0] <= bus.bus_data_in;
            if (wr_rld_hi) reload[7:4] <= bus.bus_data_in;
            if (wr_ctrl)   run         <= bus.bus_data_in[0];
            if (wr_ptc)    ptc         <= bus.bus_data_in[2:0];
            if (wr_mask)   mask        <= bus.bus_data_in[0];
            if (rd_cnt_lo) shadow      <= counter[7:4];
            interrupt_req <= factor & mask;
        end
    end

    always_comb begin
        rd_data = 4'h0;
        if (bus.bus_read_en) begin
            case (bus.bus_addr)
                ADDR_CNT_LO: rd_data = counter[3:0];
                ADDR_SHADOW: rd_data = shadow;
                ADDR_RLD_LO: rd_data = reload[3:0];
                ADDR_RLD_HI: rd_data = reload[7:4];
                ADDR_CTRL:   rd_data = {3'b000, run};
                ADDR_PTC:    rd_data = {1'b0, ptc};
                ADDR_FACTOR: rd_data = {3'b000, factor};
                ADDR_MASK:   rd_data = {3'b000, mask};
                default:     rd_data = 4'h0;
            endcase
        end
    end

    assign bus.bus_data_out = rd_data;

endmodule
